// File: rtl/tp_mul_pipe.sv
// tp_mul_pipe: pipelined signed multiplier with a valid/ready handshake.
// Stage 0 forms the exact product, the next stage applies the rounding
// right shift and the saturate/wrap range fit, and any further stages are
// pure delay. Each stage refills as soon as it is empty or being drained,
// so bubbles collapse behind a stalled output.
module tp_mul_pipe #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 16,
    parameter int P_WIDTH   = 34,
    parameter int NUM_STAGE = 3,
    parameter int SHIFT     = 0,
    parameter int SATURATE  = 1
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [A_WIDTH-1:0]          din0,
    input  logic signed [B_WIDTH-1:0]          din1,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [P_WIDTH-1:0]          dout,
    output logic                               ovf,
    output logic [$clog2(NUM_STAGE+1)-1:0]     occupancy
);
    localparam int W     = A_WIDTH + B_WIDTH;
    localparam int OCC_W = $clog2(NUM_STAGE + 1);
    localparam int LAST  = NUM_STAGE - 1;
    localparam int HI_W  = W - P_WIDTH + 2;

    // Half-LSB rounding constant; shifting a one up by SHIFT then down by one
    // gives 2^(SHIFT-1) and collapses to zero when SHIFT is zero.
    localparam logic [W:0] RND = ({{W{1'b0}}, 1'b1} << SHIFT) >> 1;

    localparam logic [P_WIDTH-1:0] SAT_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic [P_WIDTH-1:0] SAT_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

    // Round the full product, then fit it into P_WIDTH bits.
    // Returns {ovf, result}. The sum is one bit wider than the product so the
    // rounding add can never overflow; the value fits exactly when every bit
    // from the sign position of the output upward is identical.
    function automatic logic [P_WIDTH:0] fit_f(input logic signed [W-1:0] f);
        logic signed [W:0]  sum_v;
        logic signed [W:0]  r_v;
        logic               fits_v;
        logic [P_WIDTH-1:0] lo_v;
        sum_v  = $signed({f[W-1], f} + RND);
        r_v    = sum_v >>> SHIFT;
        fits_v = (r_v[W:P_WIDTH-1] == {HI_W{1'b0}}) ||
                 (r_v[W:P_WIDTH-1] == {HI_W{1'b1}});
        if ((SATURATE != 0) && !fits_v) begin
            lo_v = r_v[W] ? SAT_MIN : SAT_MAX;
        end else begin
            lo_v = r_v[P_WIDTH-1:0];
        end
        return {~fits_v, lo_v};
    endfunction

    // Number of set bits in the stage valid vector.
    function automatic logic [OCC_W-1:0] popcount_f(input logic [NUM_STAGE-1:0] v);
        logic [OCC_W-1:0] cnt_v;
        cnt_v = '0;
        for (int i = 0; i < NUM_STAGE; i++) begin
            cnt_v = cnt_v + OCC_W'(v[i]);
        end
        return cnt_v;
    endfunction

    logic [NUM_STAGE-1:0] valid_q;
    logic [NUM_STAGE-1:0] valid_d;
    logic [NUM_STAGE-1:0] ld_s;
    logic [NUM_STAGE-1:0] leave_s;
    logic [NUM_STAGE-1:0] en_s;
    logic [OCC_W-1:0]     occ_q;
    logic [P_WIDTH:0]     res_last_s;

    logic signed [W-1:0]  a_ext_s;
    logic signed [W-1:0]  b_ext_s;
    logic signed [W-1:0]  prod_s;

    assign a_ext_s = {{B_WIDTH{din0[A_WIDTH-1]}}, din0};
    assign b_ext_s = {{A_WIDTH{din1[B_WIDTH-1]}}, din1};
    assign prod_s  = a_ext_s * b_ext_s;

    // Load/leave chain resolved from the output back toward the input:
    // a stage loads when empty or when its contents move on this cycle.
    always_comb begin
        leave_s       = '0;
        ld_s          = '0;
        leave_s[LAST] = out_ready;
        ld_s[LAST]    = ~valid_q[LAST] | leave_s[LAST];
        for (int i = LAST - 1; i >= 0; i--) begin
            leave_s[i] = ld_s[i+1];
            ld_s[i]    = ~valid_q[i] | leave_s[i];
        end
    end

    // Valid-bit next state and data-load enables (data moves only with valid).
    always_comb begin
        valid_d    = valid_q;
        en_s       = '0;
        valid_d[0] = ld_s[0] ? in_valid : valid_q[0];
        en_s[0]    = ld_s[0] & in_valid;
        for (int i = 1; i < NUM_STAGE; i++) begin
            valid_d[i] = ld_s[i] ? valid_q[i-1] : valid_q[i];
            en_s[i]    = ld_s[i] & valid_q[i-1];
        end
    end

    // Stage valid bits and the registered occupancy count.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= popcount_f(valid_d);
        end
    end

    if (NUM_STAGE == 1) begin : g_single
        logic [P_WIDTH:0] res_q;

        // Single stage: multiply, round and fit in one registered step.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                res_q <= '0;
            end else if (en_s[0]) begin
                res_q <= fit_f(prod_s);
            end else begin
                res_q <= res_q;
            end
        end

        assign res_last_s = res_q;
    end else begin : g_multi
        logic signed [W-1:0] prod_q;
        logic [P_WIDTH:0]    res_q [1:NUM_STAGE-1];

        // Stage 0 captures the exact full-width product.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                prod_q <= '0;
            end else if (en_s[0]) begin
                prod_q <= prod_s;
            end else begin
                prod_q <= prod_q;
            end
        end

        // Stage 1 rounds and fits; later stages carry {ovf, result} forward.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                for (int i = 1; i < NUM_STAGE; i++) begin
                    res_q[i] <= '0;
                end
            end else begin
                if (en_s[1]) begin
                    res_q[1] <= fit_f(prod_q);
                end
                for (int i = 2; i < NUM_STAGE; i++) begin
                    if (en_s[i]) begin
                        res_q[i] <= res_q[i-1];
                    end
                end
            end
        end

        assign res_last_s = res_q[NUM_STAGE-1];
    end

    assign in_ready  = ld_s[0];
    assign out_valid = valid_q[LAST];
    assign dout      = res_last_s[P_WIDTH-1:0];
    assign ovf       = res_last_s[P_WIDTH];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_tp_mul_pipe.sv
// Bench for tp_mul_pipe: four instances (default, saturating shift-4,
// wrapping shift-4, single-stage shift-2) driven from a shared vector table,
// then handshake corner cases and a random stream on the default instance.
module tb_tp_mul_pipe;
    logic clk = 1'b0;
    logic ap_rst_n;
    logic signed [17:0] din0;
    logic signed [15:0] din1;
    logic valid_def, valid_aux, rdy_def, rdy_aux;

    logic in_ready_def, out_valid_def, ovf_def;
    logic signed [33:0] dout_def;
    logic [1:0] occ_def;
    logic in_ready_sat, out_valid_sat, ovf_sat;
    logic signed [15:0] dout_sat;
    logic [1:0] occ_sat;
    logic in_ready_wrap, out_valid_wrap, ovf_wrap;
    logic signed [15:0] dout_wrap;
    logic [1:0] occ_wrap;
    logic in_ready_rnd, out_valid_rnd, ovf_rnd;
    logic signed [15:0] dout_rnd;
    logic [0:0] occ_rnd;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_push = 1'b0;

    logic [34:0] q_def[$];
    logic [16:0] q_sat[$];
    logic [16:0] q_wrap[$];
    logic [16:0] q_rnd[$];
    logic [34:0] e_def;
    logic [16:0] e_aux;

    typedef struct {
        int     a;
        int     b;
        longint p_def;
        int     p_sat;
        bit     o_sat;
        int     p_wrap;
        bit     o_wrap;
        int     p_rnd;
        bit     o_rnd;
    } vec_t;
    vec_t vecs[15];

    always #5 clk = ~clk;

    tp_mul_pipe u_def (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(valid_def), .in_ready(in_ready_def),
        .din0(din0), .din1(din1), .out_valid(out_valid_def), .out_ready(rdy_def),
        .dout(dout_def), .ovf(ovf_def), .occupancy(occ_def));

    tp_mul_pipe #(.P_WIDTH(16), .SHIFT(4), .SATURATE(1)) u_sat (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(valid_aux), .in_ready(in_ready_sat),
        .din0(din0), .din1(din1), .out_valid(out_valid_sat), .out_ready(rdy_aux),
        .dout(dout_sat), .ovf(ovf_sat), .occupancy(occ_sat));

    tp_mul_pipe #(.P_WIDTH(16), .SHIFT(4), .SATURATE(0)) u_wrap (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(valid_aux), .in_ready(in_ready_wrap),
        .din0(din0), .din1(din1), .out_valid(out_valid_wrap), .out_ready(rdy_aux),
        .dout(dout_wrap), .ovf(ovf_wrap), .occupancy(occ_wrap));

    tp_mul_pipe #(.P_WIDTH(16), .SHIFT(2), .SATURATE(1), .NUM_STAGE(1)) u_rnd (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(valid_aux), .in_ready(in_ready_rnd),
        .din0(din0), .din1(din1), .out_valid(out_valid_rnd), .out_ready(rdy_aux),
        .dout(dout_rnd), .ovf(ovf_rnd), .occupancy(occ_rnd));

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: output with empty scoreboard", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int b);
        din0 = 18'(a);
        din1 = 16'(b);
    endtask

    // Scoreboard: sampled mid-cycle, mirrors the transfers of the next edge.
    always @(negedge clk) begin
        if (!ap_rst_n) begin
            q_def.delete();
            q_sat.delete();
            q_wrap.delete();
            q_rnd.delete();
        end else begin
            if (mon_push && valid_def && in_ready_def)
                q_def.push_back({1'b0, 34'(longint'(din0) * longint'(din1))});
            if (out_valid_def && rdy_def) begin
                if (q_def.size() == 0) unexpected("def_pop");
                else begin
                    e_def = q_def.pop_front();
                    chk("def_dout", longint'(dout_def), longint'($signed(e_def[33:0])));
                    chk("def_ovf", longint'(ovf_def), longint'(e_def[34]));
                end
            end
            if (out_valid_sat) begin
                if (q_sat.size() == 0) unexpected("sat_pop");
                else begin
                    e_aux = q_sat.pop_front();
                    chk("sat_dout", longint'(dout_sat), longint'($signed(e_aux[15:0])));
                    chk("sat_ovf", longint'(ovf_sat), longint'(e_aux[16]));
                end
            end
            if (out_valid_wrap) begin
                if (q_wrap.size() == 0) unexpected("wrap_pop");
                else begin
                    e_aux = q_wrap.pop_front();
                    chk("wrap_dout", longint'(dout_wrap), longint'($signed(e_aux[15:0])));
                    chk("wrap_ovf", longint'(ovf_wrap), longint'(e_aux[16]));
                end
            end
            if (out_valid_rnd) begin
                if (q_rnd.size() == 0) unexpected("rnd_pop");
                else begin
                    e_aux = q_rnd.pop_front();
                    chk("rnd_dout", longint'(dout_rnd), longint'($signed(e_aux[15:0])));
                    chk("rnd_ovf", longint'(ovf_rnd), longint'(e_aux[16]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int va[5];
        int vb[5];
        logic signed [33:0] hold;

        // a, b, default, sat4 (val,ovf), wrap4 (val,ovf), shift2 NS=1 (val,ovf)
        vecs[0]  = '{-131072, -32768, 64'sd4294967296, 32767, 1'b1, 0, 1'b1, 32767, 1'b1};
        vecs[1]  = '{1000, 1000, 64'sd1000000, 32767, 1'b1, -3036, 1'b1, 32767, 1'b1};
        vecs[2]  = '{-1000, 1000, -64'sd1000000, -32768, 1'b1, 3036, 1'b1, -32768, 1'b1};
        vecs[3]  = '{3, 5, 64'sd15, 1, 1'b0, 1, 1'b0, 4, 1'b0};
        vecs[4]  = '{-3, 5, -64'sd15, -1, 1'b0, -1, 1'b0, -4, 1'b0};
        vecs[5]  = '{1, 2, 64'sd2, 0, 1'b0, 0, 1'b0, 1, 1'b0};
        vecs[6]  = '{-1, 2, -64'sd2, 0, 1'b0, 0, 1'b0, 0, 1'b0};
        vecs[7]  = '{8, 1, 64'sd8, 1, 1'b0, 1, 1'b0, 2, 1'b0};
        vecs[8]  = '{-8, 1, -64'sd8, 0, 1'b0, 0, 1'b0, -2, 1'b0};
        vecs[9]  = '{131068, 4, 64'sd524272, 32767, 1'b0, 32767, 1'b0, 32767, 1'b1};
        vecs[10] = '{131070, 4, 64'sd524280, 32767, 1'b1, -32768, 1'b1, 32767, 1'b1};
        vecs[11] = '{-131072, 4, -64'sd524288, -32768, 1'b0, -32768, 1'b0, -32768, 1'b1};
        vecs[12] = '{-65538, 8, -64'sd524304, -32768, 1'b1, 32767, 1'b1, -32768, 1'b1};
        vecs[13] = '{0, 0, 64'sd0, 0, 1'b0, 0, 1'b0, 0, 1'b0};
        vecs[14] = '{131071, 32767, 64'sd4294803457, 32767, 1'b1, -10240, 1'b1, 32767, 1'b1};

        va = '{11, -22, 333, -4444, 55555};
        vb = '{7, 1234, -32768, 32767, -3};

        ap_rst_n = 1'b0; valid_def = 1'b0; valid_aux = 1'b0;
        rdy_def = 1'b1; rdy_aux = 1'b1; din0 = '0; din1 = '0;
        #2;
        chk("rst_out_valid", longint'(out_valid_def), 0);
        chk("rst_dout", longint'(dout_def), 0);
        chk("rst_ovf", longint'(ovf_def), 0);
        chk("rst_occ", longint'(occ_def), 0);
        chk("rst_in_ready", longint'(in_ready_def), 1);
        #20;
        @(negedge clk);
        ap_rst_n = 1'b1;
        step();

        // Vector table applied to all four instances back-to-back.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].a, vecs[i].b);
            valid_def = 1'b1;
            valid_aux = 1'b1;
            chk("tbl_in_ready", longint'(in_ready_def), 1);
            q_def.push_back({1'b0, vecs[i].p_def[33:0]});
            q_sat.push_back({vecs[i].o_sat, vecs[i].p_sat[15:0]});
            q_wrap.push_back({vecs[i].o_wrap, vecs[i].p_wrap[15:0]});
            q_rnd.push_back({vecs[i].o_rnd, vecs[i].p_rnd[15:0]});
            step();
        end
        valid_def = 1'b0;
        valid_aux = 1'b0;
        repeat (5) step();
        chk("tbl_left_def", longint'(q_def.size()), 0);
        chk("tbl_left_aux", longint'(q_sat.size() + q_wrap.size() + q_rnd.size()), 0);

        // Latency: result visible after the third edge counting the accept edge.
        mon_push = 1'b1;
        drive(-131072, -32768);
        valid_def = 1'b1;
        chk("lat_in_ready", longint'(in_ready_def), 1);
        step();
        valid_def = 1'b0;
        chk("lat_c1", longint'(out_valid_def), 0);
        step();
        chk("lat_c2", longint'(out_valid_def), 0);
        step();
        chk("lat_c3", longint'(out_valid_def), 1);
        chk("lat_dout", longint'(dout_def), 64'sd4294967296);
        step();

        // Backpressure: only three accepted while the output is stalled.
        rdy_def = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            drive(va[acc], vb[acc]);
            valid_def = 1'b1;
            if (in_ready_def) acc++;
            step();
        end
        chk("bp_accepted", longint'(acc), 3);
        chk("bp_occ", longint'(occ_def), 3);
        chk("bp_in_ready", longint'(in_ready_def), 0);
        chk("bp_out_valid", longint'(out_valid_def), 1);
        hold = dout_def;
        step();
        step();
        chk("bp_stable", longint'(dout_def), longint'(hold));
        chk("bp_first", longint'(dout_def), 77);
        rdy_def = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (acc < 5) begin
                drive(va[acc], vb[acc]);
                valid_def = 1'b1;
                if (in_ready_def) acc++;
            end else begin
                valid_def = 1'b0;
            end
            chk("bp_drain_valid", longint'(out_valid_def), 1);
            step();
        end
        valid_def = 1'b0;
        chk("bp_all_accepted", longint'(acc), 5);
        repeat (3) step();
        chk("bp_occ_empty", longint'(occ_def), 0);

        // Bubble collapse: new inputs fill empty slots behind a stalled result.
        drive(100, 200);
        valid_def = 1'b1;
        step();
        valid_def = 1'b0;
        step();
        step();
        chk("bub_out_valid", longint'(out_valid_def), 1);
        rdy_def = 1'b0;
        drive(-300, 400);
        valid_def = 1'b1;
        chk("bub_rdy1", longint'(in_ready_def), 1);
        step();
        drive(500, -600);
        chk("bub_rdy2", longint'(in_ready_def), 1);
        step();
        valid_def = 1'b0;
        chk("bub_occ", longint'(occ_def), 3);
        chk("bub_dout", longint'(dout_def), 20000);
        rdy_def = 1'b1;
        for (int k = 0; k < 10 && occ_def != 2'd0; k++) step();
        chk("bub_drain", longint'(occ_def), 0);

        // Mid-stream asynchronous reset with two stages occupied.
        drive(-77, 1234);
        valid_def = 1'b1;
        step();
        drive(9, 9);
        step();
        valid_def = 1'b0;
        step();
        rdy_def = 1'b0;
        chk("mr_occ_before", longint'(occ_def), 2);
        chk("mr_valid_before", longint'(out_valid_def), 1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("mr_out_valid", longint'(out_valid_def), 0);
        chk("mr_dout", longint'(dout_def), 0);
        chk("mr_ovf", longint'(ovf_def), 0);
        chk("mr_occ", longint'(occ_def), 0);
        chk("mr_in_ready", longint'(in_ready_def), 1);
        @(negedge clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge clk);
        #1;
        rdy_def = 1'b1;
        drive(-77, 1234);
        valid_def = 1'b1;
        step();
        valid_def = 1'b0;
        chk("mr_c1", longint'(out_valid_def), 0);
        step();
        chk("mr_c2", longint'(out_valid_def), 0);
        step();
        chk("mr_c3", longint'(out_valid_def), 1);
        chk("mr_dout_new", longint'(dout_def), -95018);
        step();

        // Random traffic with random backpressure, checked by the scoreboard.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                drive(int'($urandom), int'($urandom));
                valid_def = 1'b1;
            end else begin
                valid_def = 1'b0;
            end
            rdy_def = ($urandom_range(0, 2) != 0);
            step();
        end
        valid_def = 1'b0;
        rdy_def = 1'b1;
        for (int k = 0; k < 20 && occ_def != 2'd0; k++) step();
        step();
        chk("rand_occ_empty", longint'(occ_def), 0);
        chk("rand_sb_empty", longint'(q_def.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/tp_mul_pipe.md
# tp_mul_pipe

Parametrised, pipelined signed multiplier with a valid/ready handshake, used by the tracklet processor for the track-parameter products (rinv, phi0, t, z0 terms). It generalises the single-cycle 18s×16s→34 DSP product to configurable operand and result widths, configurable pipeline depth, and optional rounding right-shift with saturation or wrap. It also supports per-stage backpressure with bubble collapse, an overflow flag and an occupancy count.

## Interface
- A_WIDTH, 18, signed width of din0 (2..27)
- B_WIDTH, 16, signed width of din1 (2..18)
- P_WIDTH, 34, signed width of dout (2..A_WIDTH+B_WIDTH)
- NUM_STAGE, 3, register stages from input to dout (1..6)
- SHIFT, 0, arithmetic right shift applied to the full product (0..A_WIDTH+B_WIDTH-2)
- SATURATE, 1, 1 = clamp to P_WIDTH range, 0 = keep low P_WIDTH bits (wrap)
- ap_clk  in  1  clock; all state updates on the rising edge
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  din0/din1 valid
- in_ready  out  1  block accepts the operand pair this cycle
- din0  in  A_WIDTH  signed multiplicand
- din1  in  B_WIDTH  signed multiplier
- out_valid  out  1  dout/ovf valid
- out_ready  in  1  consumer accepts dout this cycle
- dout  out  P_WIDTH  result
- ovf  out  1  result did not fit in P_WIDTH; qualified by out_valid
- occupancy  out  clog2(NUM_STAGE+1)  number of valid stages holding data

## Operation
- Full product: F = din0 × din1, signed, A_WIDTH+B_WIDTH bits, exact.
- Rounding:
  - SHIFT>0: R = (F + 2^(SHIFT-1)) >>> SHIFT, round-half-up toward +∞.
  - The addition is done one bit wider so it never overflows.
  - SHIFT=0: R = F.
- Range fit:
  - ovf = 1 iff R < −2^(P_WIDTH−1) or R > 2^(P_WIDTH−1)−1.
  - SATURATE=1: dout = clamped R.
  - SATURATE=0: dout = R[P_WIDTH−1:0].
  - ovf is reported in both modes.
- Pipeline:
  - NUM_STAGE stages; each holds a valid bit and data. The last stage drives out_valid, dout and ovf.
  - The multiply is in stage 0. Rounding and fit are in stage min(1, NUM_STAGE−1). Remaining stages are pure delay.
  - Stage i loads when it is empty or its contents leave this cycle.
  - The last stage's contents leave when out_ready=1. Stage i<last's contents leave when stage i+1 loads.
  - Bubbles collapse: a stalled output does not block the stages behind it from filling empty slots.
- in_ready = stage-0 load condition. It is combinational from out_ready and the valid bits. There is no combinational path from in_valid.
- Transfer happens only when valid && ready on the same edge.
- occupancy = popcount of the stage valid bits. Updated every edge.
- Data registers load only on transfer. Held values are stable while out_valid=1 and out_ready=0.

## Timing
- Reset (ap_rst_n=0, asynchronous): all valid bits 0, all data registers 0.
  - Resulting outputs: out_valid=0, dout=0, ovf=0, occupancy=0.
  - in_ready=1 during reset and after it.
  - In-flight data is discarded on mid-operation reset.
- Latency: an operand pair accepted at edge k appears with out_valid=1 after edge k+NUM_STAGE−1, i.e. in the NUM_STAGE-th cycle, when there is no stall.
  - NUM_STAGE=1: the result is registered once, one cycle after acceptance.
- Throughput: 1 result per cycle while out_ready=1.
- Full pipeline: occupancy=NUM_STAGE and out_ready=0 → in_ready=0.
- Simultaneous events, pipeline full with out_ready=1:
  - in_ready=1.
  - Output pops and input pushes on the same edge.
  - occupancy is unchanged.
- Order is preserved. No result is dropped or duplicated under any out_ready pattern.

## Test plan
- Defaults, SHIFT=0. Stimulus: din0=−131072, din1=−32768, out_ready=1. Required: dout=4294967296, ovf=0, out_valid exactly 3 cycles after the transfer.
- P_WIDTH=16, SHIFT=4, SATURATE=1. Stimulus: 1000×1000. Required: dout=32767, ovf=1. Stimulus: −1000×1000. Required: dout=−32768, ovf=1. Same inputs with SATURATE=0: dout equals the low 16 bits of 62500 (−3036), ovf=1.
- SHIFT=2, P_WIDTH=16. Stimulus: 3×5. Required: dout=4. Stimulus: −3×5. Required: dout=−4. Stimulus: 1×2. Required: dout=1 (half rounds up). Stimulus: −1×2. Required: dout=0.
- Backpressure, NUM_STAGE=3. Stimulus: hold out_ready=0 and stream 5 inputs. Required: exactly 3 accepted, occupancy=3, in_ready=0, dout held stable. Then release out_ready: all 5 results drain in order, one per cycle.
- Bubble collapse. Stimulus: one input, then two idle cycles, then out_ready=0, then 2 more inputs. Required: both inputs are accepted while the first result is stalled; occupancy=3.
- Reset mid-stream: assert ap_rst_n=0 asynchronously with occupancy=2. Required: out_valid, dout, ovf and occupancy go to 0 immediately. After release, the first new input emerges NUM_STAGE cycles later with a correct value.
